// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked RISC-V data memory: funct3 codes,
// FSM encoding and the access-legality helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Illegal size code or misaligned offset; unsigned sizes exist only for loads.
    function automatic logic f3_fault(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic fault;
        case (f3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = off[0];
            F3_W:    fault = (off != 2'b00);
            F3_BU:   fault = we;
            F3_HU:   fault = we | off[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to the load funct3.
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] extended
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection followed by extension.
    always_comb begin
        case (byte_off)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            2'd3:    w_byte = word[31:24];
            default: w_byte = 8'd0;
        endcase
        if (byte_off[1]) begin
            w_half = word[31:16];
        end else begin
            w_half = word[15:0];
        end
        case (funct3)
            F3_B:    extended = {{24{w_byte[7]}}, w_byte};
            F3_BU:   extended = {24'd0, w_byte};
            F3_H:    extended = {{16{w_half[15]}}, w_half};
            F3_HU:   extended = {16'd0, w_half};
            F3_W:    extended = word;
            default: extended = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressed data memory with byte-lane stores, extended loads,
// configurable wait states behind a req/ready handshake, and fault reporting.
module data_mem_hs
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  err
);

    localparam int         IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_mem [DEPTH_WORDS];

    logic                  w_direct;
    logic                  w_go_resp;
    logic                  w_we;
    logic [2:0]            w_funct3;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_wdata;
    logic [ADDR_WIDTH-3:0] w_idx;
    logic [IDX_W-1:0]      w_row;
    logic                  w_fault;
    logic [3:0]            w_be;
    logic [31:0]           w_lane_data;
    logic [31:0]           w_word;
    logic [31:0]           w_ext;

    // With no wait states the access completes on the accepting edge itself,
    // so the request fields are used before they reach the latches.
    assign w_direct  = (r_state == S_IDLE) && req && (WAIT_STATES == 32'sd0);
    assign w_go_resp = !rst && (w_direct || ((r_state == S_WAIT) && (r_cnt == WS_LAST)));

    // Select the access fields: live request in IDLE, latched copy otherwise.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_we     = we;
            w_funct3 = funct3;
            w_addr   = addr;
            w_wdata  = wdata;
        end else begin
            w_we     = r_we;
            w_funct3 = r_funct3;
            w_addr   = r_addr;
            w_wdata  = r_wdata;
        end
    end

    assign w_idx   = w_addr[ADDR_WIDTH-1:2];
    assign w_row   = w_idx[IDX_W-1:0];
    assign w_fault = f3_fault(w_we, w_funct3, w_addr[1:0]) | (32'(w_idx) >= 32'(DEPTH_WORDS));
    assign w_word  = r_mem[w_row];

    // Byte-lane enables and replicated store data.
    always_comb begin
        w_be        = 4'b0000;
        w_lane_data = w_wdata;
        case (w_funct3)
            F3_B: begin
                w_be        = 4'b0001 << w_addr[1:0];
                w_lane_data = {4{w_wdata[7:0]}};
            end
            F3_H: begin
                w_be        = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{w_wdata[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    load_extend u_load_extend (
        .word     (w_word),
        .byte_off (w_addr[1:0]),
        .funct3   (w_funct3),
        .extended (w_ext)
    );

    // Store commit on the edge entering RESP; faulted or reset accesses never write.
    always_ff @(posedge clk) begin
        if (w_go_resp && w_we && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_row][8*i +: 8] <= w_lane_data[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM, wait counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= {ADDR_WIDTH{1'b0}};
            r_wdata  <= 32'd0;
            rdata    <= 32'd0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            if (w_go_resp) begin
                ready <= 1'b1;
                err   <= w_fault;
                if (w_fault) begin
                    rdata <= 32'd0;
                end else if (!w_we) begin
                    rdata <= w_ext;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we     <= we;
                        r_funct3 <= funct3;
                        r_addr   <= addr;
                        r_wdata  <= wdata;
                        if (WAIT_STATES == 32'sd0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == WS_LAST) begin
                        r_state <= S_RESP;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: a zero-wait 9-bit-address instance and a 3-wait-state
// instance, checked against a byte-array reference model.
module tb_data_mem_hs;

    localparam int WS_A = 0;
    localparam int WS_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_a, we_a, ready_a, err_a;
    logic [2:0]  f3_a;
    logic [8:0]  addr_a;
    logic [31:0] wd_a, rdata_a;
    logic        req_b, we_b, ready_b, err_b;
    logic [2:0]  f3_b;
    logic [7:0]  addr_b;
    logic [31:0] wd_b, rdata_b;

    data_mem_hs #(.ADDR_WIDTH(9), .DEPTH_WORDS(64), .WAIT_STATES(WS_A)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .funct3(f3_a), .addr(addr_a),
        .wdata(wd_a), .rdata(rdata_a), .ready(ready_a), .err(err_a)
    );

    data_mem_hs #(.ADDR_WIDTH(8), .DEPTH_WORDS(64), .WAIT_STATES(WS_B)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .funct3(f3_b), .addr(addr_b),
        .wdata(wd_b), .rdata(rdata_b), .ready(ready_b), .err(err_b)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  mdl [2][512];
    logic [31:0] hold [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_fault(input logic w, input logic [2:0] f3, input int a);
        logic legal;
        int   size;
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd2) ? 4 : 2);
        return !legal || (a % size != 0) || (a / 4 >= 64);
    endfunction

    function automatic logic [31:0] ref_load(input int inst, input logic [2:0] f3, input int a);
        int v;
        case (f3)
            3'd0: begin v = mdl[inst][a]; if (v >= 128) v -= 256; end
            3'd4: v = mdl[inst][a];
            3'd1: begin v = mdl[inst][a] + 256 * mdl[inst][a+1]; if (v >= 32768) v -= 65536; end
            3'd5: v = mdl[inst][a] + 256 * mdl[inst][a+1];
            default: return {mdl[inst][a+3], mdl[inst][a+2], mdl[inst][a+1], mdl[inst][a]};
        endcase
        return 32'(v);
    endfunction

    task automatic ref_store(input int inst, input logic [2:0] f3, input int a, input logic [31:0] wd);
        int n;
        n = (f3 == 3'd0) ? 1 : ((f3 == 3'd1) ? 2 : 4);
        for (int k = 0; k < n; k++) mdl[inst][a+k] = wd[8*k +: 8];
    endtask

    task automatic drive(input int inst, input logic r, input logic w, input logic [2:0] f3,
                         input int a, input logic [31:0] wd);
        if (inst == 0) begin
            req_a = r; we_a = w; f3_a = f3; addr_a = 9'(a); wd_a = wd;
        end else begin
            req_b = r; we_b = w; f3_b = f3; addr_b = 8'(a); wd_b = wd;
        end
    endtask

    task automatic set_req(input int inst, input logic r);
        if (inst == 0) req_a = r;
        else req_b = r;
    endtask

    function automatic logic rdy(input int inst);
        return (inst == 0) ? ready_a : ready_b;
    endfunction

    // One complete transaction; optionally pulses req again while waiting.
    task automatic access(input int inst, input logic w, input logic [2:0] f3, input int a,
                          input logic [31:0] wd, input logic pulse, input string tag);
        int          n, extra, ws;
        logic        got, ef;
        logic [31:0] er;
        ws = (inst == 0) ? WS_A : WS_B;
        ef = ref_fault(w, f3, a);
        if (ef) er = 32'd0;
        else if (w) begin
            er = hold[inst];
            ref_store(inst, f3, a, wd);
        end else er = ref_load(inst, f3, a);
        hold[inst] = er;
        drive(inst, 1'b1, w, f3, a, wd);
        @(posedge clk);
        @(negedge clk);
        drive(inst, 1'b0, w, f3, a, wd);
        n   = 1;
        got = rdy(inst);
        while (!got && n < 40) begin
            if (pulse) set_req(inst, n == 2);
            @(negedge clk);
            n++;
            got = rdy(inst);
        end
        set_req(inst, 1'b0);
        check({tag, "/ready_seen"}, 32'(got), 32'd1);
        check({tag, "/latency"}, 32'(n), 32'(1 + ws));
        check({tag, "/err"}, 32'((inst == 0) ? err_a : err_b), 32'(ef));
        check({tag, "/rdata"}, (inst == 0) ? rdata_a : rdata_b, er);
        @(negedge clk);
        check({tag, "/ready_width"}, 32'(rdy(inst)), 32'd0);
        if (pulse) begin
            extra = 0;
            repeat (8) begin
                @(negedge clk);
                if (rdy(inst)) extra++;
            end
            check({tag, "/ignored_req"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int          extra, inst, a;
        logic        w;
        logic [2:0]  f3;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, 0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 0, 32'd0);
        for (int i = 0; i < 512; i++) begin
            mdl[0][i] = 8'd0;
            mdl[1][i] = 8'd0;
        end
        hold[0] = 32'd0;
        hold[1] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/ready_a", 32'(ready_a), 32'd0);
        check("reset/err_a", 32'(err_a), 32'd0);
        check("reset/rdata_a", rdata_a, 32'd0);
        check("reset/ready_b", 32'(ready_b), 32'd0);
        check("reset/err_b", 32'(err_b), 32'd0);
        check("reset/rdata_b", rdata_b, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int wi = 0; wi < 64; wi++)
                access(d, 1'b1, 3'd2, wi * 4, $urandom, 1'b0, "fill");

        access(0, 1'b1, 3'd2, 8, 32'hDEADBEEF, 1'b0, "sw08");
        access(0, 1'b0, 3'd2, 8, 32'd0, 1'b0, "lw08");
        check("lw08/value", rdata_a, 32'hDEADBEEF);
        access(0, 1'b1, 3'd0, 9, 32'h00000080, 1'b0, "sb09");
        access(0, 1'b0, 3'd0, 9, 32'd0, 1'b0, "lb09");
        check("lb09/value", rdata_a, 32'hFFFFFF80);
        access(0, 1'b0, 3'd4, 9, 32'd0, 1'b0, "lbu09");
        check("lbu09/value", rdata_a, 32'h00000080);
        access(0, 1'b0, 3'd2, 8, 32'd0, 1'b0, "lw08b");
        check("lw08b/value", rdata_a, 32'hDEAD80EF);
        access(0, 1'b1, 3'd1, 10, 32'h00008001, 1'b0, "sh0a");
        access(0, 1'b0, 3'd1, 10, 32'd0, 1'b0, "lh0a");
        check("lh0a/value", rdata_a, 32'hFFFF8001);
        access(0, 1'b0, 3'd5, 10, 32'd0, 1'b0, "lhu0a");
        check("lhu0a/value", rdata_a, 32'h00008001);
        access(0, 1'b0, 3'd2, 6, 32'd0, 1'b0, "lw06_fault");
        check("lw06_fault/value", rdata_a, 32'd0);
        access(0, 1'b1, 3'd1, 3, 32'h0000A5A5, 1'b0, "sh03_fault");
        access(0, 1'b0, 3'd2, 0, 32'd0, 1'b0, "lw00_readback");
        access(0, 1'b0, 3'd2, 256, 32'd0, 1'b0, "lw100_range");
        access(0, 1'b1, 3'd4, 4, 32'hFFFFFFFF, 1'b0, "sbu_illegal");
        access(0, 1'b0, 3'd2, 4, 32'd0, 1'b0, "lw04_readback");

        access(1, 1'b0, 3'd2, 32, 32'd0, 1'b1, "ws3_pulse");
        access(1, 1'b0, 3'd2, 16, 32'd0, 1'b0, "lw10_before");

        // Store interrupted by reset during the second wait cycle.
        drive(1, 1'b1, 1'b1, 3'd2, 16, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 3'd2, 16, 32'h12345678);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold[0] = 32'd0;
        hold[1] = 32'd0;
        check("rst_wait/ready_b", 32'(ready_b), 32'd0);
        check("rst_wait/err_b", 32'(err_b), 32'd0);
        check("rst_wait/rdata_b", rdata_b, 32'd0);
        check("rst_wait/rdata_a", rdata_a, 32'd0);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready_b) extra++;
        end
        check("rst_wait/no_ready", 32'(extra), 32'd0);
        access(1, 1'b0, 3'd2, 16, 32'd0, 1'b0, "lw10_after_rst");
        vectors++;
        assert (rdata_b !== 32'h12345678) else begin
            miscompares++;
            $error("FAIL lw10_dropped_store observed=%08h expected=not 12345678", rdata_b);
        end

        for (int i = 0; i < 200; i++) begin
            inst = $urandom_range(0, 1);
            w    = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
            if (inst == 0 && $urandom_range(0, 7) == 0) a = $urandom_range(256, 511);
            access(inst, w, f3, a, $urandom, 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
Parametrised successor to the single-cycle word data memory. Byte-addressed RISC-V data memory supporting LB/LH/LW/LBU/LHU loads and SB/SH/SW stores, selected by funct3. Adds byte-lane writes, load sign/zero extension, configurable wait states behind a req/ready handshake, and misaligned/out-of-range error reporting. Sits between the EX/MEM stage and the pipeline stall logic.

Parameters:
ADDR_WIDTH, 8, byte-address width.
DEPTH_WORDS, 64, number of 32-bit words; must be <= 2**(ADDR_WIDTH-2).
WAIT_STATES, 0, extra cycles inserted before completion (0..15).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req  in  1  access request; sampled only in IDLE
we  in  1  1 = store, 0 = load
funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  ADDR_WIDTH  byte address
wdata  in  32  store data; low bytes used for B/H
rdata  out  32  load result, registered
ready  out  1  one-cycle completion pulse
err  out  1  valid with ready; access faulted

Behaviour:
- Reset values: rdata=0, ready=0, err=0, state=IDLE, wait counter=0. Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req=1 latches we/funct3/addr/wdata. Go to WAIT if WAIT_STATES>0, else RESP. req=0 stays in IDLE.
- WAIT: counter counts 1..WAIT_STATES, then goes to RESP. req is ignored (no queueing).
- RESP, present for exactly one cycle: ready=1, then back to IDLE. Next req is accepted no earlier than the cycle after ready.
- Latency: req accepted at edge T, ready high in cycle T+1+WAIT_STATES.
- Fault conditions, evaluated on latched values:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 not in the legal set. For stores only 000/001/010 are legal.
  - Word index addr[ADDR_WIDTH-1:2] >= DEPTH_WORDS.
- On fault: err=1 with ready, rdata=0, no memory write.
- Store write happens on the edge entering RESP, never earlier.
  - B writes lane addr[1:0] with wdata[7:0].
  - H writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0], little-endian.
  - W writes all four lanes.
  - Other lanes are unchanged.
- Store completion: rdata is unchanged. rdata holds its last value between responses.
- Load: the word is read on the edge entering RESP, the selected lane is extracted and extended, and the result is registered into rdata.
  - B/H sign-extend; BU/HU zero-extend; W passes the word.
- rst asserted in WAIT or RESP: FSM returns to IDLE and ready/err/rdata clear. A pending store is dropped (no write). Memory contents are retained.
- Simultaneous rst and req: rst wins and the request is lost.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding S_IDLE, S_WAIT, S_RESP.
- One sub-module load_extend: combinational; inputs word[31:0], byte_off[1:0], funct3; output extended 32-bit result. It is shared with a future cache refill path.
- Array, byte-lane write enables, FSM and counter stay in data_mem_hs.

Test Plan:
- WAIT_STATES=0: SW addr=0x08 wdata=0xDEADBEEF, then LW addr=0x08 -> ready one cycle after each accept; rdata=0xDEADBEEF, err=0.
- After previous: SB addr=0x09 wdata=0x00000080; LB 0x09 -> rdata=0xFFFFFF80; LBU 0x09 -> 0x00000080; LW 0x08 -> 0xDEAD80EF.
- SH addr=0x0A wdata=0x00008001; LH 0x0A -> 0xFFFF8001; LHU 0x0A -> 0x00008001.
- Faults: LW addr=0x06 -> ready with err=1, rdata=0; SH addr=0x03 -> err=1 and word 0 unchanged on readback; LW addr=0x100 with ADDR_WIDTH=9 -> err=1.
- WAIT_STATES=3: req at edge T -> ready exactly at cycle T+4; req pulses during WAIT are ignored (single response).
- WAIT_STATES=3: issue SW 0x10 = 0x12345678, assert rst in the 2nd WAIT cycle -> ready never pulses, outputs are 0; subsequent LW 0x10 returns the prior contents (not 0x12345678).
